// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector memory paths of CPUVectorial.
// Holds the vector and pixel types, the store FSM state encoding and the
// lane-to-pixel saturation helper, which the ALU pack path also uses.
package vec_mem_pkg;

    localparam int PIX_BITS = 8;

    typedef logic [15:0][15:0]     vec_t;
    typedef logic [PIX_BITS-1:0]   pix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } store_state_t;

    // Clamp a signed 16-bit lane value into the unsigned pixel range.
    function automatic pix_t sat_pix(input logic [15:0] v);
        pix_t res;
        if ($signed(v) < 0)
            res = '0;
        else if ($signed(v) > 16'sd255)
            res = '1;
        else
            res = v[PIX_BITS-1:0];
        return res;
    endfunction

endpackage

// File: rtl/vector_pixel_store_image_ram.sv
// image_ram: byte-wide image buffer with one write port and one registered
// read port.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - async active-low reset (clears the read register only)
//   wr_en    - write strobe; wr_addr must already be range-checked
//   wr_addr  - byte address of the write
//   wr_data  - byte to write
//   rd_addr  - byte address to read; out-of-range addresses read as 0
//   rd_data  - registered read data (old contents on a same-address write)
module image_ram
    import vec_mem_pkg::*;
#(
    parameter int DEPTH = 9216
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  pix_t        wr_data,
    input  logic [15:0] rd_addr,
    output pix_t        rd_data
);

    localparam int AW = $clog2(DEPTH);

    pix_t mem [DEPTH];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          rd_in_range;
    logic          wr_in_range;

    assign wr_idx      = wr_addr[AW-1:0];
    assign rd_idx      = rd_addr[AW-1:0];
    assign rd_in_range = rd_addr < 16'(DEPTH);
    assign wr_in_range = wr_addr < 16'(DEPTH);

    // Storage array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range)
            mem[wr_idx] <= wr_data;
    end

    // The read samples the array before this edge's write lands, giving
    // read-before-write behaviour on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_in_range)
            rd_data <= mem[rd_idx];
        else
            rd_data <= '0;
    end

endmodule

// File: rtl/vector_pixel_store.sv
// vector_pixel_store: stores the low LANES lanes of a 16x16-bit vector as
// consecutive saturated 8-bit pixels into the image buffer, one lane per
// cycle, under a Start/Busy/Done handshake.
// Ports:
//   CLK, RST_N - clock and async active-low reset
//   Start      - store request, sampled only while idle
//   Addr       - base byte address of lane 0
//   WD         - vector data, lane k = WD[k] (signed 16-bit)
//   Mask       - per-lane write enable
//   Busy       - high while writing and during the Done cycle
//   Done       - one-cycle completion pulse
//   Err        - sticky out-of-range flag, cleared by reset or a new store
//   RdAddr     - dump-port byte address
//   RdData     - registered pixel at RdAddr
module vector_pixel_store
    import vec_mem_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int PIX_SIZE     = 8,
    parameter int LANES        = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                Start,
    input  logic [15:0]         Addr,
    input  vec_t                WD,
    input  logic [15:0]         Mask,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    input  logic [15:0]         RdAddr,
    output logic [PIX_SIZE-1:0] RdData
);

    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;

    store_state_t state_q, state_d;
    logic [3:0]   lane_q;
    logic [15:0]  addr_q;
    vec_t         wd_q;
    logic [15:0]  mask_q;

    logic         accept;
    logic         last_lane;
    logic [15:0]  wr_addr;
    logic         wr_in_range;
    logic         lane_en;
    logic         wr_en;
    logic         lane_oob;
    pix_t         wr_data;

    // Lane datapath: address wraps naturally in 16 bits.
    assign wr_addr     = addr_q + {12'd0, lane_q};
    assign wr_in_range = wr_addr < 16'(DEPTH);
    assign lane_en     = mask_q[lane_q];
    assign wr_data     = sat_pix(wd_q[lane_q]);
    assign last_lane   = lane_q == 4'(LANES - 1);

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        wr_en    = 1'b0;
        lane_oob = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                Busy     = 1'b1;
                wr_en    = lane_en && wr_in_range;
                lane_oob = lane_en && !wr_in_range;
                if (last_lane)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, lane counter, request latches and the sticky error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            mask_q  <= '0;
            Err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= Addr;
                wd_q   <= WD;
                mask_q <= Mask;
                lane_q <= '0;
                Err    <= 1'b0;
            end else if (state_q == ST_WRITE) begin
                lane_q <= lane_q + 4'd1;
                if (lane_oob)
                    Err <= 1'b1;
            end
        end
    end

    image_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (RdAddr),
        .rd_data (RdData)
    );

endmodule

// File: tb/tb_vector_pixel_store.sv
// Directed testbench for vector_pixel_store.
module tb_vector_pixel_store;

    localparam int LANES = 8;
    localparam int DEPTH = 96 * 96;

    logic              CLK;
    logic              RST_N;
    logic              Start;
    logic [15:0]       Addr;
    logic [15:0][15:0] WD;
    logic [15:0]       Mask;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [15:0]       RdAddr;
    logic [7:0]        RdData;

    int tests_run;
    int tests_failed;

    vector_pixel_store #(
        .IMAGE_WIDTH (96),
        .IMAGE_HEIGHT(96),
        .PIX_SIZE    (8),
        .LANES       (LANES)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Start (Start),
        .Addr  (Addr),
        .WD    (WD),
        .Mask  (Mask),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err),
        .RdAddr(RdAddr),
        .RdData(RdData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request and let edge 0 accept it.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0][15:0] wd,
                                 input logic [15:0] m);
        Addr  = a;
        WD    = wd;
        Mask  = m;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Wait for the FSM to return to idle, bounded.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic read_pix(input logic [15:0] a, output logic [7:0] v);
        RdAddr = a;
        tick();
        v = RdData;
    endtask

    task automatic test_reset();
        RST_N  = 1'b0;
        Start  = 1'b0;
        Addr   = '0;
        WD     = '0;
        Mask   = '0;
        RdAddr = '0;
        #2;
        tests_run++;
        if (Busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        tests_run++;
        if (Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", Done); end
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", Err); end
        tests_run++;
        if (RdData !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rddata got %h want 00", RdData); end
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0][15:0] wd;
        logic [7:0]        v;
        int                edges;
        bit                seen;
        wd = '0;
        for (int k = 0; k < 8; k++) wd[k] = 16'(k + 1);
        applyStimulus(16'h0010, wd, 16'hFFFF);
        tests_run++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_after_accept got busy=%b done=%b want busy=1 done=0", Busy, Done);
        end
        edges = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Done) begin
                edges = i;
                seen  = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen || edges != LANES) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_latency got %0d edges (seen=%b) want %0d", edges, seen, LANES);
        end
        tick();
        tests_run++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_pulse got done=%b busy=%b want 0 0", Done, Busy);
        end
        for (int k = 0; k < 8; k++) begin
            read_pix(16'(16'h0010 + k), v);
            tests_run++;
            if (v !== 8'(k + 1)) begin
                tests_failed++;
                $display("[TB] FAIL basic_byte%0d got %h want %h", k, v, 8'(k + 1));
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0][15:0] wd;
        logic [7:0]        exp_b [8];
        logic [7:0]        v;
        bit                ok;
        wd = '0;
        wd[0] = 16'hFFFF; wd[1] = 16'h0000; wd[2] = 16'h00FF; wd[3] = 16'h0100;
        wd[4] = 16'h7FFF; wd[5] = 16'h8000; wd[6] = 16'h0080; wd[7] = 16'h00FF;
        exp_b = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hFF};
        applyStimulus(16'h0040, wd, 16'hFFFF);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL sat_timeout got busy=%b want 0", Busy); end
        for (int k = 0; k < 8; k++) begin
            read_pix(16'(16'h0040 + k), v);
            tests_run++;
            if (v !== exp_b[k]) begin
                tests_failed++;
                $display("[TB] FAIL sat_lane%0d got %h want %h", k, v, exp_b[k]);
            end
        end
    endtask

    task automatic test_mask_boundary();
        logic [15:0][15:0] wd;
        logic [7:0]        v;
        logic [7:0]        exp_b [4];
        bit                ok;
        // Prefill 9212..9215 so untouched bytes have known values.
        wd = '0;
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'h51 + k);
        applyStimulus(16'(DEPTH - 4), wd, 16'h000F);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL mask_prefill_timeout got busy=%b want 0", Busy); end
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'h61 + k);
        applyStimulus(16'(DEPTH - 4), wd, 16'h00A5);
        for (int e = 1; e <= 5; e++) tick();
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_err_early got %b want 0", Err); end
        tick();
        tests_run++;
        if (Err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mask_err_lane5 got %b want 1", Err); end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL mask_timeout got busy=%b want 0", Busy); end
        exp_b = '{8'h61, 8'h52, 8'h63, 8'h54};
        for (int k = 0; k < 4; k++) begin
            read_pix(16'(DEPTH - 4 + k), v);
            tests_run++;
            if (v !== exp_b[k]) begin
                tests_failed++;
                $display("[TB] FAIL mask_byte%0d got %h want %h", DEPTH - 4 + k, v, exp_b[k]);
            end
        end
        tests_run++;
        if (Err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mask_err_sticky got %b want 1", Err); end
        applyStimulus(16'h0200, wd, 16'h0000);
        tests_run++;
        if (Err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_err_clear got %b want 0", Err); end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL mask_clear_timeout got busy=%b want 0", Busy); end
    endtask

    task automatic test_start_during_busy();
        logic [15:0][15:0] wd;
        int                done_cnt;
        bit                ok;
        wd = '0;
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'h70 + k);
        applyStimulus(16'h0300, wd, 16'hFFFF);
        done_cnt = 0;
        for (int e = 1; e <= 10; e++) begin
            Start = (e == 3 || e == 8 || e == 10);
            tick();
            Start = 1'b0;
            if (Done) done_cnt++;
            if (e == 9) begin
                tests_run++;
                if (Busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_idle_edge9 got %b want 0", Busy); end
            end
            if (e == 10) begin
                tests_run++;
                if (Busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_accept_edge10 got %b want 1", Busy); end
            end
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL busy_done_count got %0d want 1", done_cnt); end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL busy_timeout got busy=%b want 0", Busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0][15:0] wd;
        logic [7:0]        v;
        logic [7:0]        exp_b [8];
        bit                ok;
        wd = '0;
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'h11 + k);
        applyStimulus(16'h0100, wd, 16'hFFFF);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL rst_prefill_timeout got busy=%b want 0", Busy); end
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'h21 + k);
        applyStimulus(16'h0100, wd, 16'hFFFF);
        for (int e = 1; e <= 4; e++) tick();
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_outputs got busy=%b done=%b err=%b want 0 0 0", Busy, Done, Err);
        end
        RST_N = 1'b1;
        tick();
        exp_b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h15, 8'h16, 8'h17, 8'h18};
        for (int k = 0; k < 8; k++) begin
            read_pix(16'(16'h0100 + k), v);
            tests_run++;
            if (v !== exp_b[k]) begin
                tests_failed++;
                $display("[TB] FAIL rst_mid_byte%0d got %h want %h", k, v, exp_b[k]);
            end
        end
    endtask

    task automatic test_read_collision();
        logic [15:0][15:0] wd;
        bit                ok;
        wd = '0;
        wd[2] = 16'h0033;
        applyStimulus(16'h0500, wd, 16'hFFFF);
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL coll_prefill_timeout got busy=%b want 0", Busy); end
        RdAddr = 16'h0502;
        wd[2] = 16'h0044;
        applyStimulus(16'h0500, wd, 16'hFFFF);
        for (int e = 1; e <= 3; e++) tick();
        tests_run++;
        if (RdData !== 8'h33) begin tests_failed++; $display("[TB] FAIL coll_old_byte got %h want 33", RdData); end
        tick();
        tests_run++;
        if (RdData !== 8'h44) begin tests_failed++; $display("[TB] FAIL coll_new_byte got %h want 44", RdData); end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL coll_timeout got busy=%b want 0", Busy); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_mask_boundary();
        test_start_during_busy();
        test_reset_mid();
        test_read_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
